irq_pending_capture: RTL and testbench

//   Upstream request-capture stage for the 8-to-3 priority encoder. Converts raw

---
 rtl/irq_pending_capture.sv | 96 +++++++++
 tb/tb_irq_pending_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_capture.sv
// Request capture stage: latches raw request lines into a pending vector and
// presents the highest-index unmasked pending line with a valid/ack handshake.
module irq_pending_capture #(
    parameter int N    = 8,
    parameter int IDW  = 3,
    parameter bit EDGE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic           clr_all,
    input  logic           irq_ack,
    output logic [N-1:0]   pend,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   req_d_q, req_d_d;
    logic [IDW-1:0] id_q, id_d;

    logic [N-1:0]   set_v;
    logic [N-1:0]   clr_v;
    logic [N-1:0]   masked;
    logic [IDW-1:0] top_id;

    always_comb begin
        set_v   = EDGE ? (req & ~req_d_q) : req;
        clr_v   = '0;
        if (state_q == PRESENT && irq_ack) begin
            clr_v[id_q] = 1'b1;
        end
        // Set is OR-ed in after the ack clear so a coincident new event survives.
        pend_d  = clr_all ? '0 : ((pend_q & ~clr_v) | set_v);
        req_d_d = req;

        masked = pend_q & mask;
        top_id = '0;
        for (int i = 0; i < N; i++) begin
            if (masked[i]) begin
                top_id = IDW'(i);
            end
        end

        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (!clr_all && (masked != '0)) begin
                    id_d    = top_id;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (clr_all) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_d_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_d_q <= req_d_d;
            id_q    <= id_d;
        end
    end

    assign pend      = pend_q;
    assign irq_valid = (state_q == PRESENT);
    assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
// Bench for irq_pending_capture: edge-capture and level-capture instances
// driven in parallel and compared against a behavioural model.
module tb_irq_pending_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] mask = '0;
    logic       clr_all = 1'b0;
    logic       irq_ack = 1'b0;

    logic [7:0] pend_e, pend_l;
    logic       valid_e, valid_l;
    logic [2:0] id_e, id_l;

    int errors = 0;
    int checks = 0;

    // Model: index 0 = edge-capture instance, index 1 = level-capture instance
    logic [7:0] m_pend [2];
    logic [7:0] m_prev [2];
    int         m_mode [2];
    logic [2:0] m_id   [2];

    always #5 clk = ~clk;

    irq_pending_capture #(.N(8), .IDW(3), .EDGE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .clr_all(clr_all), .irq_ack(irq_ack),
        .pend(pend_e), .irq_valid(valid_e), .irq_id(id_e)
    );

    irq_pending_capture #(.N(8), .IDW(3), .EDGE(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .clr_all(clr_all), .irq_ack(irq_ack),
        .pend(pend_l), .irq_valid(valid_l), .irq_id(id_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            m_pend[e] = '0;
            m_prev[e] = '0;
            m_mode[e] = 0;
            m_id[e]   = '0;
        end
    endtask

    // Mode 0 = waiting, 1 = presenting, 2 = forced idle gap after an ack
    task automatic model_step();
        logic [7:0] s, c, np, vis;
        for (int e = 0; e < 2; e++) begin
            s  = (e == 0) ? (req & ~m_prev[e]) : req;
            c  = (m_mode[e] == 1 && irq_ack) ? (8'd1 << m_id[e]) : 8'd0;
            np = clr_all ? 8'd0 : ((m_pend[e] & ~c) | s);
            vis = m_pend[e] & mask;
            if (m_mode[e] == 0) begin
                if (!clr_all && vis != 0) begin
                    m_id[e]   = 3'($clog2(int'(vis) + 1) - 1);
                    m_mode[e] = 1;
                end
            end else if (m_mode[e] == 1) begin
                if (clr_all) m_mode[e] = 0;
                else if (irq_ack) m_mode[e] = 2;
            end else begin
                m_mode[e] = 0;
            end
            m_pend[e] = np;
            m_prev[e] = req;
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pend_e"},  pend_e,  m_pend[0]);
        chk({tag, ".valid_e"}, {7'd0, valid_e}, {7'd0, m_mode[0] == 1});
        chk({tag, ".id_e"},    {5'd0, id_e},    {5'd0, m_id[0]});
        chk({tag, ".pend_l"},  pend_l,  m_pend[1]);
        chk({tag, ".valid_l"}, {7'd0, valid_l}, {7'd0, m_mode[1] == 1});
        chk({tag, ".id_l"},    {5'd0, id_l},    {5'd0, m_id[1]});
    endtask

    // Inputs are applied at the falling edge; outputs sampled at the next one.
    task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] m,
                       input logic c, input logic a);
        req = r; mask = m; clr_all = c; irq_ack = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.pend", pend_e, 8'h00);
        chk("rst.valid", {7'd0, valid_e}, 8'h00);
        rst = 1'b0;

        // Single pulse on line 2
        cyc("t1a", 8'h04, 8'hFF, 0, 0);
        chk("t1.pend04", pend_e, 8'h04);
        cyc("t1b", 8'h00, 8'hFF, 0, 0);
        chk("t1.id2", {5'd0, id_e}, 8'h02);
        chk("t1.valid", {7'd0, valid_e}, 8'h01);
        cyc("t1c", 8'h00, 8'hFF, 0, 1);
        chk("t1.pend00", pend_e, 8'h00);
        cyc("t1d", 8'h00, 8'hFF, 0, 0);
        cyc("t1e", 8'h00, 8'hFF, 0, 0);
        chk("t1.stay0", {7'd0, valid_e}, 8'h00);

        // Two lines at once: highest first, gap between IDs
        cyc("t2a", 8'h81, 8'hFF, 0, 0);
        cyc("t2b", 8'h00, 8'hFF, 0, 0);
        chk("t2.id7", {5'd0, id_e}, 8'h07);
        cyc("t2c", 8'h00, 8'hFF, 0, 1);
        cyc("t2d", 8'h00, 8'hFF, 0, 0);
        chk("t2.gaplow", {7'd0, valid_e}, 8'h00);
        cyc("t2e", 8'h00, 8'hFF, 0, 0);
        chk("t2.id0", {5'd0, id_e}, 8'h00);
        chk("t2.valid", {7'd0, valid_e}, 8'h01);
        cyc("t2f", 8'h00, 8'hFF, 0, 1);
        cyc("t2g", 8'h00, 8'hFF, 0, 0);
        chk("t2.pend00", pend_e, 8'h00);

        // Masked line stays latched until unmasked
        cyc("t3a", 8'h80, 8'h7F, 0, 0);
        chk("t3.pend80", pend_e, 8'h80);
        cyc("t3b", 8'h00, 8'h7F, 0, 0);
        cyc("t3c", 8'h00, 8'h7F, 0, 0);
        chk("t3.masked", {7'd0, valid_e}, 8'h00);
        cyc("t3d", 8'h00, 8'hFF, 0, 0);
        chk("t3.id7", {5'd0, id_e}, 8'h07);
        cyc("t3e", 8'h00, 8'hFF, 0, 1);
        cyc("t3f", 8'h00, 8'hFF, 0, 0);
        cyc("t3g", 8'h00, 8'hFF, 0, 0);

        // New edge coinciding with ack on the presented line
        cyc("t4a", 8'h08, 8'hFF, 0, 0);
        cyc("t4b", 8'h00, 8'hFF, 0, 0);
        chk("t4.id3", {5'd0, id_e}, 8'h03);
        cyc("t4c", 8'h08, 8'hFF, 0, 1);
        chk("t4.kept", pend_e, 8'h08);
        cyc("t4d", 8'h00, 8'hFF, 0, 0);
        cyc("t4e", 8'h00, 8'hFF, 0, 0);
        chk("t4.again", {6'd0, valid_e, id_e == 3'd3}, 8'h03);
        cyc("t4f", 8'h00, 8'hFF, 0, 1);
        cyc("t4g", 8'h00, 8'hFF, 0, 0);
        cyc("t4h", 8'h00, 8'hFF, 0, 0);

        // clr_all while presenting, then async reset mid-present
        cyc("t5a", 8'h2C, 8'hFF, 0, 0);
        cyc("t5b", 8'h00, 8'hFF, 0, 0);
        chk("t5.id5", {5'd0, id_e}, 8'h05);
        cyc("t5c", 8'h00, 8'hFF, 1, 1);
        chk("t5.pend00", pend_e, 8'h00);
        chk("t5.valid0", {7'd0, valid_e}, 8'h00);
        cyc("t5d", 8'h50, 8'hFF, 0, 0);
        cyc("t5e", 8'h00, 8'hFF, 0, 0);
        chk("t5.pres", {7'd0, valid_e}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("t5.rst_pend", pend_e, 8'h00);
        chk("t5.rst_valid", {7'd0, valid_e}, 8'h00);
        chk("t5.rst_id", {5'd0, id_e}, 8'h00);
        chk("t5.rst_pend_l", pend_l, 8'h00);
        model_reset();
        req = 8'h02;
        @(negedge clk);
        rst = 1'b0;
        cyc("t5f", 8'h02, 8'hFF, 0, 0);
        chk("t5.reledge", pend_e, 8'h02);
        cyc("t5g", 8'h00, 8'hFF, 0, 0);
        cyc("t5h", 8'h00, 8'hFF, 0, 1);
        cyc("t5i", 8'h00, 8'hFF, 0, 0);
        cyc("t5j", 8'h00, 8'hFF, 0, 0);

        // Held request: level instance re-sets after ack, edge instance does not
        cyc("t6a", 8'h20, 8'hFF, 0, 0);
        cyc("t6b", 8'h20, 8'hFF, 0, 0);
        chk("t6.id5", {5'd0, id_l}, 8'h05);
        cyc("t6c", 8'h20, 8'hFF, 0, 1);
        chk("t6.lvl_pend", pend_l, 8'h20);
        chk("t6.edg_pend", pend_e, 8'h00);
        cyc("t6d", 8'h20, 8'hFF, 0, 0);
        cyc("t6e", 8'h20, 8'hFF, 0, 0);
        chk("t6.again", {6'd0, valid_l, id_l == 3'd5}, 8'h03);
        cyc("t6f", 8'h00, 8'hFF, 1, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            logic [7:0]  rq, mk;
            r  = $urandom;
            rq = r[7:0] & r[15:8] & r[23:16];
            mk = r[24] ? 8'hFF : 8'($urandom);
            cyc("rnd", rq, mk, $urandom_range(0, 40) == 0,
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
